// File: rtl/hazard_pkg.sv
// Shared constants, scoreboard entry type and small helpers for the hazard scoreboard.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package hazard_pkg;

    // Stage indices as reported on the forward selects
    localparam int STG_GRF = 0;
    localparam int STG_E   = 1;
    localparam int STG_M   = 2;
    localparam int STG_W   = 3;

    // Tuse value meaning "this source is not read" (all-ones for the default 2-bit field)
    localparam logic [1:0] TUSE_NONE = 2'b11;

    // Typical Tnew at E-entry
    localparam logic [1:0] TNEW_ALU  = 2'd1;
    localparam logic [1:0] TNEW_LOAD = 2'd2;
    localparam logic [1:0] TNEW_LINK = 2'd0;

    // Typical Tuse
    localparam logic [1:0] TUSE_BRANCH   = 2'd0;
    localparam logic [1:0] TUSE_ALU      = 2'd1;
    localparam logic [1:0] TUSE_STORE_RT = 2'd2;

    // Entry fields are sized for the widest supported configuration;
    // narrower register/Tnew fields are zero-extended on the way in.
    localparam int SB_AW_MAX = 8;
    localparam int SB_TW_MAX = 4;

    typedef struct packed {
        logic                 v;
        logic                 we;
        logic [SB_AW_MAX-1:0] wa;
        logic [SB_TW_MAX-1:0] tnew;
        logic [SB_AW_MAX-1:0] rs;
        logic [SB_AW_MAX-1:0] rt;
    } sb_entry_t;

    // An entry produces register s if it is a live writer of s; r0 is never produced
    function automatic logic sb_match(input sb_entry_t e, input logic [SB_AW_MAX-1:0] s);
        return e.v && e.we && (e.wa == s) && (s != '0);
    endfunction

    // Entry as it looks one stage later: Tnew counts down and sticks at zero
    function automatic sb_entry_t sb_age(input sb_entry_t e);
        sb_entry_t r;
        r = e;
        if (e.tnew != '0) begin
            r.tnew = e.tnew - SB_TW_MAX'(1);
        end
        return r;
    endfunction

endpackage

// File: rtl/hazard_scoreboard_if.sv
// D/E-stage hazard query bundle between the datapath (master) and the hazard scoreboard (slave).
// Latency: n/a (wiring only).
// Backpressure: stall is the only backpressure; it holds F/D while E..W keep moving.
interface hazard_scoreboard_if #(
    parameter int AW = 5,
    parameter int TW = 2,
    parameter int SW = 2
);
    logic          d_valid;
    logic [AW-1:0] d_rs;
    logic [AW-1:0] d_rt;
    logic [TW-1:0] d_tuse_rs;
    logic [TW-1:0] d_tuse_rt;
    logic          d_we;
    logic [AW-1:0] d_wa;
    logic [TW-1:0] d_tnew;
    logic          d_md_use;
    logic          e_md_start;
    logic          e_md_div;
    logic          flush;

    logic          stall;
    logic          md_busy;
    logic [SW-1:0] fwd_rs_d;
    logic [SW-1:0] fwd_rt_d;
    logic [SW-1:0] fwd_rs_e;
    logic [SW-1:0] fwd_rt_e;

    modport master (
        output d_valid, d_rs, d_rt, d_tuse_rs, d_tuse_rt, d_we, d_wa, d_tnew,
        output d_md_use, e_md_start, e_md_div, flush,
        input  stall, md_busy, fwd_rs_d, fwd_rt_d, fwd_rs_e, fwd_rt_e
    );

    modport slave (
        input  d_valid, d_rs, d_rt, d_tuse_rs, d_tuse_rt, d_we, d_wa, d_tnew,
        input  d_md_use, e_md_start, e_md_div, flush,
        output stall, md_busy, fwd_rs_d, fwd_rt_d, fwd_rs_e, fwd_rt_e
    );
endinterface

// File: rtl/hazard_scoreboard_md_busy_ctr.sv
// Mult/div busy countdown: a start loads LAT-1, then counts down to zero.
// Latency: busy asserts the cycle after start and stays high for LAT-1 cycles.
// Backpressure: none; a start while busy simply reloads (last start wins).
module md_busy_ctr #(
    parameter int MULT_LAT = 5,
    parameter int DIV_LAT  = 10
) (
    input  logic clk,
    input  logic reset,
    input  logic start,
    input  logic div,
    output logic busy
);
    localparam int MAXL = (MULT_LAT > DIV_LAT) ? MULT_LAT : DIV_LAT;
    localparam int CW   = (MAXL > 1) ? $clog2(MAXL) : 1;

    logic [CW-1:0] cnt;

    // Load on start, otherwise count down while non-zero
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt <= '0;
        end else if (start) begin
            cnt <= div ? CW'(DIV_LAT - 1) : CW'(MULT_LAT - 1);
        end else if (cnt != '0) begin
            cnt <= cnt - CW'(1);
        end
    end

    assign busy = (cnt != '0);
endmodule

// File: rtl/hazard_scoreboard.sv
// Hazard scoreboard: DEPTH-stage shift scoreboard with Tnew countdown -> stall + bypass selects.
// Latency: stall/fwd are combinational from state and D inputs; allocation takes effect next cycle.
// Backpressure: raises stall to hold F/D (bubble into E); E..W never stall. Optional HAZARD_STATS_EN adds stall counters.
module hazard_scoreboard
    import hazard_pkg::*;
#(
    parameter int NREG     = 32,
    parameter int AW       = 5,
    parameter int DEPTH    = 3,
    parameter int TW       = 2,
    parameter int MULT_LAT = 5,
    parameter int DIV_LAT  = 10,
    parameter int SW       = 2
) (
    input  logic               clk,
    input  logic               reset,
    hazard_scoreboard_if.slave bus
`ifdef HAZARD_STATS_EN
    ,
    output logic [31:0]        stall_cnt,
    output logic [31:0]        md_stall_cnt
`endif
);
    localparam logic [TW-1:0] TUSE_ALL = {TW{1'b1}};

    typedef struct packed {
        logic                 hit;
        logic [SW-1:0]        stg;
        logic [SB_TW_MAX-1:0] tnew;
    } hit_t;

    sb_entry_t sb [1:DEPTH];

    hit_t      rs_d, rt_d, rs_e, rt_e;
    logic      stall_rs, stall_rt, stall_md, stall_any;
    logic      md_busy;
    logic      alloc;
    sb_entry_t new_entry;

    // Youngest producer of s among stages lo..DEPTH; older matches are shadowed
    function automatic hit_t youngest(input logic [SB_AW_MAX-1:0] s, input int lo);
        hit_t r;
        r = '0;
        for (int k = DEPTH; k >= lo; k--) begin
            if (sb_match(sb[k], s)) begin
                r.hit  = 1'b1;
                r.stg  = SW'(k);
                r.tnew = sb[k].tnew;
            end
        end
        return r;
    endfunction

    // Source lookups, stall decision and the entry that D would allocate
    always_comb begin
        rs_d = youngest(SB_AW_MAX'(bus.d_rs), STG_E);
        rt_d = youngest(SB_AW_MAX'(bus.d_rt), STG_E);
        rs_e = youngest(sb[1].rs, STG_M);
        rt_e = youngest(sb[1].rt, STG_M);

        stall_rs  = rs_d.hit && (bus.d_tuse_rs != TUSE_ALL) &&
                    (rs_d.tnew > SB_TW_MAX'(bus.d_tuse_rs));
        stall_rt  = rt_d.hit && (bus.d_tuse_rt != TUSE_ALL) &&
                    (rt_d.tnew > SB_TW_MAX'(bus.d_tuse_rt));
        stall_md  = bus.d_valid && bus.d_md_use && (md_busy || bus.e_md_start);
        stall_any = bus.d_valid && (stall_rs || stall_rt || stall_md);

        // A flushed instruction never allocates, even when it is also stalled
        alloc = bus.d_valid && !stall_any && !bus.flush;

        new_entry      = '0;
        new_entry.v    = 1'b1;
        // Addresses beyond the register file name nothing a reader could want
        new_entry.we   = bus.d_we && (int'(bus.d_wa) < NREG);
        new_entry.wa   = SB_AW_MAX'(bus.d_wa);
        new_entry.tnew = SB_TW_MAX'(bus.d_tnew);
        new_entry.rs   = SB_AW_MAX'(bus.d_rs);
        new_entry.rt   = SB_AW_MAX'(bus.d_rt);
    end

    // Scoreboard shift: D (or a bubble) enters stage 1, older entries age by one stage
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int k = 1; k <= DEPTH; k++) begin
                sb[k] <= '0;
            end
        end else begin
            sb[1] <= alloc ? new_entry : '0;
            for (int k = 2; k <= DEPTH; k++) begin
                sb[k] <= sb_age(sb[k-1]);
            end
        end
    end

    md_busy_ctr #(
        .MULT_LAT (MULT_LAT),
        .DIV_LAT  (DIV_LAT)
    ) u_md_busy_ctr (
        .clk   (clk),
        .reset (reset),
        .start (bus.e_md_start),
        .div   (bus.e_md_div),
        .busy  (md_busy)
    );

    // A stalled D instruction will not use a bypass this cycle, so its selects read GRF
    assign bus.stall    = stall_any;
    assign bus.md_busy  = md_busy;
    assign bus.fwd_rs_d = (!stall_any && rs_d.hit && rs_d.tnew == '0) ? rs_d.stg : SW'(STG_GRF);
    assign bus.fwd_rt_d = (!stall_any && rt_d.hit && rt_d.tnew == '0) ? rt_d.stg : SW'(STG_GRF);
    assign bus.fwd_rs_e = (sb[1].v && rs_e.hit && rs_e.tnew == '0) ? rs_e.stg : SW'(STG_GRF);
    assign bus.fwd_rt_e = (sb[1].v && rt_e.hit && rt_e.tnew == '0) ? rt_e.stg : SW'(STG_GRF);

`ifdef HAZARD_STATS_EN
    // Saturating counts of stalled cycles and of cycles stalled by mult/div
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            stall_cnt    <= '0;
            md_stall_cnt <= '0;
        end else begin
            if (stall_any && stall_cnt != '1) begin
                stall_cnt <= stall_cnt + 32'd1;
            end
            if (stall_md && md_stall_cnt != '1) begin
                md_stall_cnt <= md_stall_cnt + 32'd1;
            end
        end
    end
`endif

endmodule
